alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer end of the execute-stage ALU interface.
- Decodes a MIPS instruction's opcode/funct fields into the 4-bit ALU control code and builds both ALU operands.
- Registers the result into the ID/EX pipeline register, which drives the ALU's src1/src2/alu_ctrl inputs directly.
- Supports stall, flush and a saturating illegal-instruction counter.

Parameters:
- WIDTH, 32: datapath width. Must be at least 16.
- CNT_W, 8: illegal-instruction counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  decode stage presents an instruction this cycle.
- i_opcode  in  6  instruction bits [31:26].
- i_funct  in  6  instruction bits [5:0].
- i_shamt  in  5  instruction bits [10:6].
- i_imm  in  16  instruction bits [15:0].
- i_rs_data  in  WIDTH  rs register value (already forwarded).
- i_rt_data  in  WIDTH  rt register value (already forwarded).
- i_rt_addr  in  5  rt index.
- i_rd_addr  in  5  rd index.
- i_stall  in  1  hold the pipeline register.
- i_flush  in  1  squash the pipeline register.
- o_valid  out  1  registered instruction valid.
- o_alu_ctrl  out  4  ALU control code.
- o_src1  out  WIDTH  ALU operand 1.
- o_src2  out  WIDTH  ALU operand 2.
- o_dest_reg  out  5  write-back register index.
- o_reg_write  out  1  instruction writes a register.
- o_is_branch  out  1  instruction is beq/bne.
- o_branch_ne  out  1  1 = bne, 0 = beq.
- o_illegal  out  1  registered instruction is unrecognised.
- o_illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Extension rules: SE = sign-extend imm to WIDTH; ZE = zero-extend imm to WIDTH.
- Defaults for R-type: src1 = rs, src2 = rt, dest = rd, reg_write = 1.
- R-type (opcode 0x00) decode by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x2A SLT; 0x2B SLTU.
  - 0x00/0x02/0x03 SLL/SRL/SRA: src1 = rt, src2 = shamt zero-extended.
  - 0x04/0x06/0x07 SLLV/SRLV/SRAV: src1 = rt, src2 = rs (the ALU uses src2[4:0]).
  - Any other funct: illegal.
- I-type decode by opcode:
  - 0x08/0x09 ADD, src2 = SE.
  - 0x0A SLT, SE. 0x0B SLTU, SE.
  - 0x0C AND, ZE. 0x0D OR, ZE. 0x0E XOR, ZE.
  - 0x0F lui: SLL, src1 = ZE, src2 = 16.
  - 0x23 lw: ADD, rs + SE.
  - I-type dest = rt, reg_write = 1.
  - 0x2B sw: ADD, rs + SE, reg_write = 0.
  - 0x04 beq / 0x05 bne: SUB, src1 = rs, src2 = rt, reg_write = 0, is_branch = 1, branch_ne = opcode[0].
  - Any other opcode: illegal.
- Illegal instruction registers: alu_ctrl = ADD, src1 = src2 = 0, reg_write = 0, is_branch = 0, o_illegal = 1.
- Latency: exactly 1 cycle from input to outputs. Decode is combinational; all outputs come from registers.
- Register update priority, highest first:
  1. i_rst: o_valid = 0, o_illegal_cnt = 0, all other outputs 0 (alu_ctrl 0000).
  2. i_flush: o_valid = 0, reg_write = 0, is_branch = 0, o_illegal = 0; data fields unchanged. Flush wins over stall.
  3. i_stall: all outputs hold.
  4. Otherwise: load the decoded fields; o_valid = i_valid.
- When i_valid = 0 and the register loads: reg_write, is_branch and illegal are forced to 0; data fields load normally.
- o_illegal_cnt:
  - Increments by 1 on a load with i_valid = 1 and an illegal decode.
  - Saturates at 2^CNT_W - 1.
  - Does not increment on stall or flush cycles; cleared only by reset.
- Reset asserted during a stall or flush: reset wins; the next cycle shows reset values.
- Consecutive stalls hold indefinitely; i_valid is ignored while stalled.

Test Plan:
- Reset: assert i_rst 2 cycles with random inputs -> all outputs 0, o_illegal_cnt = 0.
- add: opcode 0x00, funct 0x20, rs = 5, rt = 7, rd = 3 -> next cycle alu_ctrl = 0000, src1 = 5, src2 = 7, dest = 3, reg_write = 1, o_valid = 1.
- Immediates:
  - addi imm 0xFFFF, rs = 10 -> src2 = 0xFFFFFFFF, alu_ctrl ADD.
  - ori imm 0xFFFF -> src2 = 0x0000FFFF, alu_ctrl OR.
  - lui imm 0x1234 -> src1 = 0x00001234, src2 = 16, alu_ctrl SLL.
- Shifts:
  - sra shamt 4, rt = 0x80000000 -> src1 = 0x80000000, src2 = 4, alu_ctrl 0111.
  - srav with rs = 3 -> src2 = 3.
- Branch and store:
  - bne -> alu_ctrl SUB, is_branch = 1, branch_ne = 1, reg_write = 0.
  - sw -> reg_write = 0, alu_ctrl ADD.
- Hazards and illegal:
  - Load add, then stall 3 cycles with a different instruction on inputs -> outputs hold.
  - Flush together with stall -> o_valid = 0 the next cycle.
  - 300 illegal opcodes (0x3F) with CNT_W = 8 -> o_illegal = 1 each cycle, o_illegal_cnt stops at 255.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS ALU decode and ID/EX pipeline register feeding the execute-stage ALU.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic [4:0]       i_shamt,
    input  logic [15:0]      i_imm,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic [4:0]       i_rt_addr,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [3:0]       o_alu_ctrl,
    output logic [WIDTH-1:0] o_src1,
    output logic [WIDTH-1:0] o_src2,
    output logic [4:0]       o_dest_reg,
    output logic             o_reg_write,
    output logic             o_is_branch,
    output logic             o_branch_ne,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [WIDTH-1:0] se_imm;
    logic [WIDTH-1:0] ze_imm;
    logic [WIDTH-1:0] ze_shamt;

    assign se_imm   = WIDTH'($signed(i_imm));
    assign ze_imm   = WIDTH'(i_imm);
    assign ze_shamt = WIDTH'(i_shamt);

    logic [3:0]       d_ctrl;
    logic [WIDTH-1:0] d_src1;
    logic [WIDTH-1:0] d_src2;
    logic [4:0]       d_dest;
    logic             d_rw;
    logic             d_br;
    logic             d_bne;
    logic             d_ill;

    always_comb begin
        d_ctrl = ALU_ADD;
        d_src1 = i_rs_data;
        d_src2 = i_rt_data;
        d_dest = i_rt_addr;
        d_rw   = 1'b1;
        d_br   = 1'b0;
        d_bne  = 1'b0;
        d_ill  = 1'b0;
        case (i_opcode)
            6'h00: begin
                d_dest = i_rd_addr;
                case (i_funct)
                    6'h20, 6'h21: d_ctrl = ALU_ADD;
                    6'h22, 6'h23: d_ctrl = ALU_SUB;
                    6'h24:        d_ctrl = ALU_AND;
                    6'h25:        d_ctrl = ALU_OR;
                    6'h26:        d_ctrl = ALU_XOR;
                    6'h2A:        d_ctrl = ALU_SLT;
                    6'h2B:        d_ctrl = ALU_SLTU;
                    6'h00, 6'h02, 6'h03: begin
                        d_ctrl = (i_funct[1:0] == 2'b00) ? ALU_SLL :
                                 (i_funct[1:0] == 2'b10) ? ALU_SRL : ALU_SRA;
                        d_src1 = i_rt_data;
                        d_src2 = ze_shamt;
                    end
                    // Variable shifts: the ALU consumes only src2[4:0].
                    6'h04, 6'h06, 6'h07: begin
                        d_ctrl = (i_funct[1:0] == 2'b00) ? ALU_SLL :
                                 (i_funct[1:0] == 2'b10) ? ALU_SRL : ALU_SRA;
                        d_src1 = i_rt_data;
                        d_src2 = i_rs_data;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: d_src2 = se_imm;
            6'h0A: begin d_ctrl = ALU_SLT;  d_src2 = se_imm; end
            6'h0B: begin d_ctrl = ALU_SLTU; d_src2 = se_imm; end
            6'h0C: begin d_ctrl = ALU_AND;  d_src2 = ze_imm; end
            6'h0D: begin d_ctrl = ALU_OR;   d_src2 = ze_imm; end
            6'h0E: begin d_ctrl = ALU_XOR;  d_src2 = ze_imm; end
            6'h0F: begin
                d_ctrl = ALU_SLL;
                d_src1 = ze_imm;
                d_src2 = WIDTH'(16);
            end
            6'h23: d_src2 = se_imm;
            6'h2B: begin d_src2 = se_imm; d_rw = 1'b0; end
            6'h04, 6'h05: begin
                d_ctrl = ALU_SUB;
                d_rw   = 1'b0;
                d_br   = 1'b1;
                d_bne  = i_opcode[0];
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_ctrl = ALU_ADD;
            d_src1 = '0;
            d_src2 = '0;
            d_dest = '0;
            d_rw   = 1'b0;
            d_br   = 1'b0;
            d_bne  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_alu_ctrl    <= '0;
            o_src1        <= '0;
            o_src2        <= '0;
            o_dest_reg    <= '0;
            o_reg_write   <= 1'b0;
            o_is_branch   <= 1'b0;
            o_branch_ne   <= 1'b0;
            o_illegal     <= 1'b0;
            o_illegal_cnt <= '0;
        end else if (i_flush) begin
            // Squash only the side-effecting flags; operand fields are left stale.
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_is_branch <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (!i_stall) begin
            o_valid     <= i_valid;
            o_alu_ctrl  <= d_ctrl;
            o_src1      <= d_src1;
            o_src2      <= d_src2;
            o_dest_reg  <= d_dest;
            o_reg_write <= d_rw & i_valid;
            o_is_branch <= d_br & i_valid;
            o_branch_ne <= d_bne;
            o_illegal   <= d_ill & i_valid;
            if (i_valid && d_ill && (o_illegal_cnt != '1))
                o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        is_branch;
    logic        branch_ne;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int passes = 0;
    int exp_cnt;

    alu_issue_stage #(.WIDTH(32), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_opcode(opcode),
        .i_funct(funct), .i_shamt(shamt), .i_imm(imm), .i_rs_data(rs_data),
        .i_rt_data(rt_data), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr),
        .i_stall(stall), .i_flush(flush), .o_valid(out_valid),
        .o_alu_ctrl(alu_ctrl), .o_src1(src1), .o_src2(src2),
        .o_dest_reg(dest_reg), .o_reg_write(reg_write), .o_is_branch(is_branch),
        .o_branch_ne(branch_ne), .o_illegal(illegal), .o_illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rta, input logic [4:0] rda);
        valid = 1'b1; opcode = op; funct = fn; shamt = sh; imm = im;
        rs_data = rs; rt_data = rt; rt_addr = rta; rd_addr = rda;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        valid = 1'b1; opcode = 6'($urandom); funct = 6'($urandom); shamt = 5'($urandom);
        imm = 16'($urandom); rs_data = $urandom; rt_data = $urandom;
        rt_addr = 5'($urandom); rd_addr = 5'($urandom);
        tick();
        opcode = 6'($urandom); rs_data = $urandom;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", alu_ctrl, 0);
        check("rst_src1", src1, 0);
        check("rst_src2", src2, 0);
        check("rst_dest", dest_reg, 0);
        check("rst_rw", reg_write, 0);
        check("rst_br", is_branch, 0);
        check("rst_bne", branch_ne, 0);
        check("rst_ill", illegal, 0);
        check("rst_cnt", illegal_cnt, 0);
        rst = 1'b0;

        instr(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 5'd9, 5'd3);
        tick();
        check("add_ctrl", alu_ctrl, 4'b0000);
        check("add_src1", src1, 5);
        check("add_src2", src2, 7);
        check("add_dest", dest_reg, 3);
        check("add_rw", reg_write, 1);
        check("add_valid", out_valid, 1);

        instr(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd10, 32'd1, 5'd4, 5'd6);
        tick();
        check("addi_src2", src2, 32'hFFFFFFFF);
        check("addi_src1", src1, 10);
        check("addi_ctrl", alu_ctrl, 4'b0000);
        check("addi_dest", dest_reg, 4);

        instr(6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'd1, 32'd2, 5'd5, 5'd6);
        tick();
        check("ori_src2", src2, 32'h0000FFFF);
        check("ori_ctrl", alu_ctrl, 4'b0011);

        instr(6'h0F, 6'h00, 5'd0, 16'h1234, 32'd99, 32'd2, 5'd8, 5'd6);
        tick();
        check("lui_src1", src1, 32'h00001234);
        check("lui_src2", src2, 16);
        check("lui_ctrl", alu_ctrl, 4'b0101);

        instr(6'h00, 6'h03, 5'd4, 16'h0, 32'd1, 32'h80000000, 5'd8, 5'd2);
        tick();
        check("sra_src1", src1, 32'h80000000);
        check("sra_src2", src2, 4);
        check("sra_ctrl", alu_ctrl, 4'b0111);

        instr(6'h00, 6'h07, 5'd9, 16'h0, 32'd3, 32'hF0000000, 5'd8, 5'd2);
        tick();
        check("srav_src2", src2, 3);
        check("srav_src1", src1, 32'hF0000000);
        check("srav_ctrl", alu_ctrl, 4'b0111);

        instr(6'h05, 6'h00, 5'd0, 16'h0010, 32'd11, 32'd12, 5'd8, 5'd2);
        tick();
        check("bne_ctrl", alu_ctrl, 4'b0001);
        check("bne_br", is_branch, 1);
        check("bne_ne", branch_ne, 1);
        check("bne_rw", reg_write, 0);
        check("bne_src2", src2, 12);

        instr(6'h2B, 6'h00, 5'd0, 16'h8000, 32'd100, 32'd12, 5'd8, 5'd2);
        tick();
        check("sw_rw", reg_write, 0);
        check("sw_ctrl", alu_ctrl, 4'b0000);
        check("sw_src2", src2, 32'hFFFF8000);
        check("sw_br", is_branch, 0);

        instr(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, 5'd9, 5'd3);
        tick();
        instr(6'h00, 6'h22, 5'd0, 16'h0, 32'd50, 32'd70, 5'd1, 5'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = i[0];
            tick();
            check("stall_src1", src1, 5);
            check("stall_ctrl", alu_ctrl, 4'b0000);
            check("stall_valid", out_valid, 1);
            check("stall_rw", reg_write, 1);
        end
        flush = 1'b1;
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_rw", reg_write, 0);
        check("flush_src1", src1, 5);
        stall = 1'b0; flush = 1'b0;

        instr(6'h00, 6'h20, 5'd0, 16'h0, 32'd9, 32'd7, 5'd9, 5'd3);
        valid = 1'b0;
        tick();
        check("nv_valid", out_valid, 0);
        check("nv_rw", reg_write, 0);
        check("nv_src1", src1, 9);

        exp_cnt = 0;
        instr(6'h3F, 6'h00, 5'd0, 16'h1, 32'd1, 32'd2, 5'd3, 5'd4);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            check("ill_flag", illegal, 1);
            check("ill_cnt", illegal_cnt, exp_cnt);
        end
        check("ill_src1", src1, 0);
        check("ill_rw", reg_write, 0);

        rst = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        check("ill_flush_flag", illegal, 0);
        check("ill_flush_cnt", illegal_cnt, 255);

        rst = 1'b1;
        tick();
        check("rst_stall_cnt", illegal_cnt, 0);
        check("rst_stall_valid", out_valid, 0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        instr(6'h3F, 6'h00, 5'd0, 16'h1, 32'd1, 32'd2, 5'd3, 5'd4);
        tick();
        check("ill_after_rst_cnt", illegal_cnt, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
